ercd8_iter_div: RTL and testbench



---
 rtl/ercd_pkg.sv | 17 +
 rtl/ercd_div_step.sv | 29 ++
 rtl/ercd8_iter_div.sv | 151 +++++++++++++++
 tb/tb_ercd8_iter_div.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ercd_pkg.sv
// Shared definitions for the ercd iterative divider: FSM states, default widths
// and the saturated all-ones result returned on divide-by-zero or overflow.
package ercd_pkg;

  localparam int DW_DEF    = 8;
  localparam int CNT_W_DEF = 4;

  // Wide enough for any practical DW; callers slice [DW-1:0].
  localparam logic [63:0] ERR_ONES = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ercd_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and emit one quotient bit.
module ercd_div_step #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] i_pr,
  input  logic          i_bit,
  input  logic [DW-1:0] i_div,
  output logic [DW-1:0] o_pr,
  output logic          o_q
);

  logic [DW:0] w_t;

  assign w_t = {i_pr, i_bit};

  // The compare is DW+1 bits wide; the difference is always below the divisor,
  // so its low DW bits carry the full result.
  always_comb begin
    if (w_t >= {1'b0, i_div}) begin
      o_pr = w_t[DW-1:0] - i_div;
      o_q  = 1'b1;
    end else begin
      o_pr = w_t[DW-1:0];
      o_q  = 1'b0;
    end
  end

endmodule

// File: rtl/ercd8_iter_div.sv
// Iterative restoring divider (2*DW / DW -> DW quotient + remainder), one quotient
// bit per clock, valid/ready on both sides. DIV_APPROX_EN adds truncated iterations.
module ercd8_iter_div
  import ercd_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [2*DW-1:0] dat_in_a,
  input  logic [DW-1:0]   dat_in_b,
`ifdef DIV_APPROX_EN
  input  logic [2:0]      trunc,
`endif
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [DW-1:0]   dat_o_quo,
  output logic [DW-1:0]   dat_o_rem,
  output logic            err_div0,
  output logic            err_ovf
);

  state_t r_state, w_state_next;

  logic [DW-1:0]    r_pr, r_sh, r_div, r_quo, r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err_div0, r_err_ovf;

  logic             w_idle, w_bad_div0, w_bad_ovf, w_bad, w_last, w_q, w_bit_in;
  logic [DW-1:0]    w_pr_in, w_div_in, w_pr_n, w_quo_n, w_quo_fin, w_rem_fin;
  logic [CNT_W-1:0] w_cnt_cur, w_cnt_inc, w_iters, w_trunc_cur;

  assign w_idle     = (r_state == IDLE);
  assign w_bad_div0 = (dat_in_b == '0);
  assign w_bad_ovf  = (dat_in_a[2*DW-1:DW] >= dat_in_b);
  assign w_bad      = w_bad_div0 | w_bad_ovf;

  // The first step runs on the accepting edge straight from the input operands,
  // so a full division completes DW cycles after accept.
  assign w_pr_in   = w_idle ? dat_in_a[2*DW-1:DW] : r_pr;
  assign w_bit_in  = w_idle ? dat_in_a[DW-1]      : r_sh[DW-1];
  assign w_div_in  = w_idle ? dat_in_b            : r_div;
  assign w_cnt_cur = w_idle ? '0                  : r_cnt;
  assign w_cnt_inc = w_cnt_cur + CNT_W'(1);

  ercd_div_step #(.DW(DW)) u_step (
    .i_pr  (w_pr_in),
    .i_bit (w_bit_in),
    .i_div (w_div_in),
    .o_pr  (w_pr_n),
    .o_q   (w_q)
  );

`ifdef DIV_APPROX_EN
  logic [CNT_W-1:0] r_trunc, w_trunc_in;

  assign w_trunc_in  = (int'(trunc) >= DW) ? CNT_W'(DW - 1) : CNT_W'(trunc);
  assign w_trunc_cur = w_idle ? w_trunc_in : r_trunc;
`else
  assign w_trunc_cur = '0;
`endif

  assign w_iters   = CNT_W'(DW) - w_trunc_cur;
  assign w_last    = (w_cnt_inc == w_iters);
  assign w_quo_n   = (w_idle ? '0 : (r_quo << 1)) | DW'(w_q);
  assign w_quo_fin = w_quo_n << w_trunc_cur;
  assign w_rem_fin = (w_trunc_cur != '0) ? '0 : w_pr_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_rdy       = 1'b0;
    out_vld      = 1'b0;
    case (r_state)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_vld) w_state_next = (w_bad || w_last) ? DONE : CALC;
      end
      CALC: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_vld = 1'b1;
        if (out_rdy) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pr       <= '0;
      r_sh       <= '0;
      r_div      <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_err_div0 <= 1'b0;
      r_err_ovf  <= 1'b0;
`ifdef DIV_APPROX_EN
      r_trunc    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (in_vld) begin
          r_err_div0 <= w_bad_div0;
          r_err_ovf  <= !w_bad_div0 && w_bad_ovf;
          if (w_bad) begin
            r_quo <= ERR_ONES[DW-1:0];
            r_rem <= ERR_ONES[DW-1:0];
          end else begin
            r_pr  <= w_pr_n;
            r_sh  <= dat_in_a[DW-1:0] << 1;
            r_div <= dat_in_b;
            r_cnt <= w_cnt_inc;
            r_quo <= w_last ? w_quo_fin : w_quo_n;
            if (w_last) r_rem <= w_rem_fin;
`ifdef DIV_APPROX_EN
            r_trunc <= w_trunc_in;
`endif
          end
        end
        CALC: begin
          r_pr  <= w_pr_n;
          r_sh  <= r_sh << 1;
          r_cnt <= w_cnt_inc;
          r_quo <= w_last ? w_quo_fin : w_quo_n;
          if (w_last) r_rem <= w_rem_fin;
        end
        DONE: if (out_rdy) begin
          r_err_div0 <= 1'b0;
          r_err_ovf  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign dat_o_quo = r_quo;
  assign dat_o_rem = r_rem;
  assign err_div0  = r_err_div0;
  assign err_ovf   = r_err_ovf;

endmodule

// File: tb/tb_ercd8_iter_div.sv
// Self-checking bench for ercd8_iter_div: directed and random divisions checked
// against plain integer division. Covers DIV_APPROX_EN when that macro is defined.
module tb_ercd8_iter_div;

  localparam int DW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [15:0] dat_in_a = '0;
  logic [7:0]  dat_in_b = '0;
`ifdef DIV_APPROX_EN
  logic [2:0]  trunc = '0;
`endif
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [7:0]  dat_o_quo, dat_o_rem;
  logic        err_div0, err_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ercd8_iter_div dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .dat_in_a (dat_in_a),
    .dat_in_b (dat_in_b),
`ifdef DIV_APPROX_EN
    .trunc    (trunc),
`endif
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .dat_o_quo(dat_o_quo),
    .dat_o_rem(dat_o_rem),
    .err_div0 (err_div0),
    .err_ovf  (err_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_vld"}, 32'(out_vld), 32'(0));
    chk({tag, "_in_rdy"},  32'(in_rdy),  32'(1));
    chk({tag, "_quo"},     32'(dat_o_quo), 32'(0));
    chk({tag, "_rem"},     32'(dat_o_rem), 32'(0));
    chk({tag, "_div0"},    32'(err_div0), 32'(0));
    chk({tag, "_ovf"},     32'(err_ovf),  32'(0));
  endtask

  // One full transaction: model, issue, wait for result, optional backpressure, drain.
  task automatic run_div(input logic [15:0] a, input logic [7:0] b, input int t, input int hold);
    int       eq, er, el, lat, w, tc, ahi;
    logic     ed, eo;
    tc  = (t >= DW) ? DW - 1 : t;
    ahi = int'(a) / 256;
    ed  = (b == 8'd0);
    eo  = !ed && (ahi >= int'(b));
    if (ed || eo) begin
      eq = 255; er = 255; el = 1;
    end else begin
      eq = ((int'(a) / int'(b)) / (1 << tc)) * (1 << tc);
      er = (tc != 0) ? 0 : int'(a) % int'(b);
      el = DW - tc;
    end

    @(negedge clk);
    w = 0;
    while (!in_rdy && w < 30) begin
      @(negedge clk);
      w++;
    end
    chk("in_rdy_idle", 32'(in_rdy), 32'(1));

    dat_in_a = a;
    dat_in_b = b;
`ifdef DIV_APPROX_EN
    trunc = 3'(t);
`endif
    in_vld = 1'b1;
    @(posedge clk);
    #1;
    in_vld   = 1'b0;
    dat_in_a = 16'($urandom);
    dat_in_b = 8'($urandom);

    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_vld && lat < 20);

    chk("latency", 32'(lat), 32'(el));
    chk("quo",     32'(dat_o_quo), 32'(eq));
    chk("rem",     32'(dat_o_rem), 32'(er));
    chk("div0",    32'(err_div0), 32'(ed));
    chk("ovf",     32'(err_ovf),  32'(eo));

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_out_vld", 32'(out_vld), 32'(1));
      chk("bp_in_rdy",  32'(in_rdy),  32'(0));
      chk("bp_quo",     32'(dat_o_quo), 32'(eq));
      chk("bp_rem",     32'(dat_o_rem), 32'(er));
    end

    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    out_rdy = 1'b0;
    @(negedge clk);
    chk("drain_out_vld", 32'(out_vld), 32'(0));
    chk("drain_in_rdy",  32'(in_rdy),  32'(1));
    chk("drain_div0",    32'(err_div0), 32'(0));
    chk("drain_ovf",     32'(err_ovf),  32'(0));

    $display("div a=0x%04h b=0x%02h t=%0d -> quo=0x%02h rem=0x%02h lat=%0d (exp quo=0x%02h rem=0x%02h lat=%0d)",
             a, b, t, dat_o_quo, dat_o_rem, lat, eq, er, el);
  endtask

  initial begin
    logic [7:0] ra, rb;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    run_div(16'h00C8, 8'h07, 0, 0);
    run_div(16'hFE01, 8'hFF, 0, 0);
    run_div(16'h1234, 8'h00, 0, 0);
    run_div(16'h1234, 8'h12, 0, 0);
    run_div(16'h00C8, 8'h07, 0, 5);
    run_div(16'h00FF, 8'h01, 0, 0);
    run_div(16'h0100, 8'h01, 0, 0);
    run_div(16'h0000, 8'h05, 0, 0);
    run_div(16'hFEFF, 8'hFF, 0, 0);
    run_div(16'hFF00, 8'hFF, 0, 0);

    repeat (150) begin
      ra = 8'($urandom);
      rb = 8'($urandom_range(1, 255));
      run_div(16'(ra) * 16'(rb), rb, 0, 0);
    end

    repeat (150) begin
      rb = 8'($urandom_range(1, 255));
      run_div({8'($urandom_range(0, int'(rb) - 1)), 8'($urandom)}, rb, 0, 0);
    end

    repeat (20) run_div(16'($urandom), 8'($urandom), 0, $urandom_range(0, 2));

    // Abort mid-calculation: reset during the 4th CALC cycle.
    @(negedge clk);
    dat_in_a = 16'h00C8;
    dat_in_b = 8'h07;
    in_vld   = 1'b1;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    @(negedge clk);
    rst_n = 1'b1;
    run_div(16'h00C8, 8'h07, 0, 0);

`ifdef DIV_APPROX_EN
    run_div(16'hFE01, 8'hFF, 3, 0);
    run_div(16'hFE01, 8'hFF, 7, 0);
    repeat (40) begin
      rb = 8'($urandom_range(1, 255));
      run_div({8'($urandom_range(0, int'(rb) - 1)), 8'($urandom)}, rb, $urandom_range(0, 7), 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
